sd_cmd_serializer: RTL and testbench
====================================

// Module: sd_cmd_serializer
// PURPOSE
//  Host-side SD command transmitter. Feeds the card's Cmd line: accepts {index, argument}, builds the 48-bit token
//  {start 0, tx 1, index[5:0], arg[31:0], CRC7, end 1} and serialises it MSB-first, one bit per SClk strobe.
//  CRC7 is computed on the fly. After the end bit the line is released for a fixed Ncc gap before the next command.
// PARAMETERS
//  NCC_BITS  8  strobes the line stays released after the end bit before oReady rises again (1..63)
// PORTS
//  Clk        in   1   system clock, single clock domain
//  nResetSync in   1   synchronous active-low reset, sampled on rising Clk
//  iStrobe    in   1   one-Clk pulse per SD bit period; marks the END of the current bit period
//  iValid     in   1   command request valid
//  iIndex     in   6   command index
//  iArg       in   32  command argument
//  oReady     out  1   serializer idle, can accept this cycle
//  oCmd       out  1   Cmd line data (tristate driver data)
//  oCmdEn     out  1   Cmd line drive enable; 0 = released (pull-up)
//  oDone      out  1   one-Clk pulse: end bit period finished
// BEHAVIOUR
//  Reset (nResetSync=0 at a Clk edge): state Idle, oReady=1, oCmd=1, oCmdEn=0, oDone=0, counters/CRC cleared.
//   Reset mid-command aborts it: the line is released on the next edge and no oDone is issued.
//  States: Idle -> Content(40 bits) -> Crc(7) -> End(1) -> Gap(NCC_BITS) -> Idle.
//  Idle: oReady=1, oCmdEn=0, oCmd=1. On an edge with iValid&oReady: latch inputs, load shift reg {0,1,iIndex,iArg},
//   clear CRC, go Content. Next cycle oCmdEn=1, oCmd=start bit 0 (zero-strobe latency). iStrobe in the accept cycle is ignored.
//  Content: on each iStrobe, CRC <= crc7_next(CRC, oCmd), shift out the next bit; bit counter 0..39.
//   On the strobe ending bit 39, go Crc and present CRC bit 6 (the updated CRC includes bit 39).
//  Crc: CRC bits 6..0 MSB-first, one per strobe; on the strobe ending bit 0, go End, oCmd=1.
//  End: oCmdEn=1, oCmd=1; on its strobe: oDone=1 for exactly that next Clk cycle, oCmdEn=0, go Gap.
//  Gap: oCmdEn=0, oReady=0; count NCC_BITS strobes, then Idle (oReady=1 the cycle after the last gap strobe).
//  Outputs are registered and change only on Clk edges; between strobes every output holds its value.
//  oReady=0 in all states but Idle. iValid while busy is ignored, not queued. Inputs are sampled only at accept.
//  CRC7: poly x^7+x^3+1, init 0, fed with the 40 content bits. crc7_next(c,b): f=c[6]^b; c<={c[5:3],c[2]^f,c[1:0],f}.
//  Counters: 6-bit bit counter, reused for the Gap count. No wrap is reachable.
//  iStrobe held high every Clk is legal: one bit per Clk, 48 Clk per token.
// STRUCTURE
//  Package sd_cmd_pkg: state enum (Idle, Content, Crc, End, Gap), constants cCrc7Poly=7'h09, cContentBits=40,
//   cTokenBits=48, function crc7_next.
//  Sub-module sd_crc7: serial CRC7 with clear, enable and data-bit inputs; exposes the 7-bit register.
//   The serializer selects CRC bits by the bit counter.
//  Top: FSM, 40-bit shift register, bit counter, output registers.
// TESTING
//  CMD0, arg 0, strobe every 4 Clk -> line 0x40_00000000_95 (CRC 0x4A); oDone 1 cycle after 48th strobe;
//   oReady back after 8 more strobes.
//  CMD8, arg 0x000001AA, strobe every Clk -> 0x48_000001AA_87 (CRC 0x43); oCmdEn high for exactly 48 Clk.
//  CMD17, arg 0 -> 0x51_00000000_55 (CRC 0x2A).
//  Hold iValid high with a new index throughout the CMD17 transmission -> only one command accepted.
//   The second is accepted only after the Gap, with the inputs sampled then.
//  Assert nResetSync low at Content bit 20 -> next edge: oCmdEn=0, oCmd=1, oReady=1, no oDone.
//   A fresh CMD0 then serialises correctly with the CRC re-initialised.
//  iStrobe coincident with accept -> start bit still held for a full strobe interval (first advance at the next strobe).
//  Random strobe spacing 1..7 Clk, 200 random commands -> bench-decoded tokens match the reference CRC7 model.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// SD command serializer shared types and CRC7 helper.
// State encoding, token geometry and the serial CRC7 step.
package sd_cmd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONTENT,
      S_CRC,
      S_END,
      S_GAP
   } state_t;

   localparam logic [6:0] cCrc7Poly    = 7'h09;
   localparam int         cContentBits = 40;
   localparam int         cTokenBits   = 48;

   // One serial step of x^7+x^3+1, MSB-first data.
   function automatic logic [6:0] crc7_next(
      input logic [6:0] c,
      input logic       b
   );
      logic f;
      f = c[6] ^ b;
      return {c[5:0], 1'b0} ^ (f ? cCrc7Poly : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator for the SD command token.
// Clear wins over enable; register exposed for bit selection.
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [6:0] o_crc
);

   logic [6:0] r_crc;

   // CRC register: sync clear, otherwise fold in one bit per enable.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_crc <= 7'h00;
      end else if (i_clr) begin
         r_crc <= 7'h00;
      end else if (i_en) begin
         r_crc <= crc7_next(r_crc, i_bit);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_serializer.sv
// Host-side SD Cmd line transmitter.
// Sends {0,1,index,arg,CRC7,1} MSB-first, then holds an Ncc gap.
module sd_cmd_serializer
   import sd_cmd_pkg::*;
#(
   parameter int NCC_BITS = 8
) (
   input  logic        Clk,
   input  logic        nResetSync,
   input  logic        iStrobe,
   input  logic        iValid,
   input  logic [5:0]  iIndex,
   input  logic [31:0] iArg,
   output logic        oReady,
   output logic        oCmd,
   output logic        oCmdEn,
   output logic        oDone
);

   localparam logic [5:0] cLastContent = 6'(cContentBits - 1);
   localparam logic [5:0] cLastCrc     = 6'd6;
   localparam logic [5:0] cGapLast     = 6'(NCC_BITS - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [39:0] r_shift;
   logic [39:0] w_shift_nxt;
   logic [5:0]  r_cnt;
   logic [5:0]  w_cnt_nxt;
   logic        r_cmd;
   logic        w_cmd_nxt;
   logic        r_cmd_en;
   logic        w_en_nxt;
   logic        r_ready;
   logic        w_ready_nxt;
   logic        r_done;
   logic        w_done_nxt;
   logic        w_crc_clr;
   logic        w_crc_en;
   logic [6:0]  w_crc;
   logic [6:0]  w_crc_upd;

   sd_crc7 u_crc (
      .i_clk   (Clk),
      .i_rst_n (nResetSync),
      .i_clr   (w_crc_clr),
      .i_en    (w_crc_en),
      .i_bit   (r_cmd),
      .o_crc   (w_crc)
   );

   // CRC including the bit now on the line; its MSB leads the CRC field.
   assign w_crc_upd = crc7_next(w_crc, r_cmd);

   // State, datapath and output registers.
   always_ff @(posedge Clk) begin
      if (!nResetSync) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_cmd    <= 1'b1;
         r_cmd_en <= 1'b0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_cnt    <= w_cnt_nxt;
         r_cmd    <= w_cmd_nxt;
         r_cmd_en <= w_en_nxt;
         r_ready  <= w_ready_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Next-state and next-output logic; everything holds between strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_cmd_nxt   = r_cmd;
      w_en_nxt    = r_cmd_en;
      w_ready_nxt = r_ready;
      w_done_nxt  = 1'b0;
      w_crc_clr   = 1'b0;
      w_crc_en    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_ready_nxt = 1'b1;
            w_en_nxt    = 1'b0;
            w_cmd_nxt   = 1'b1;
            if (iValid && r_ready) begin
               w_shift_nxt = {1'b0, 1'b1, iIndex, iArg};
               w_crc_clr   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_CONTENT;
               w_en_nxt    = 1'b1;
               w_cmd_nxt   = 1'b0;
               w_ready_nxt = 1'b0;
            end
         end
         S_CONTENT: begin
            if (iStrobe) begin
               w_crc_en    = 1'b1;
               w_shift_nxt = {r_shift[38:0], r_shift[39]};
               if (r_cnt == cLastContent) begin
                  w_state_nxt = S_CRC;
                  w_cnt_nxt   = '0;
                  w_cmd_nxt   = w_crc_upd[6];
               end else begin
                  w_cnt_nxt = r_cnt + 6'd1;
                  w_cmd_nxt = r_shift[38];
               end
            end
         end
         S_CRC: begin
            if (iStrobe) begin
               if (r_cnt == cLastCrc) begin
                  w_state_nxt = S_END;
                  w_cnt_nxt   = '0;
                  w_cmd_nxt   = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 6'd1;
                  w_cmd_nxt = w_crc[3'd5 - r_cnt[2:0]];
               end
            end
         end
         S_END: begin
            if (iStrobe) begin
               w_done_nxt  = 1'b1;
               w_en_nxt    = 1'b0;
               w_cmd_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (iStrobe) begin
               if (r_cnt == cGapLast) begin
                  w_state_nxt = S_IDLE;
                  w_ready_nxt = 1'b1;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 6'd1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign oReady = r_ready;
   assign oCmd   = r_cmd;
   assign oCmdEn = r_cmd_en;
   assign oDone  = r_done;

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Self-checking bench for sd_cmd_serializer.
// Directed token table, multi-cycle corner sequences, random commands.
module tb_sd_cmd_serializer;

   localparam int NCC = 8;

   logic        Clk;
   logic        nResetSync;
   logic        iStrobe;
   logic        iValid;
   logic [5:0]  iIndex;
   logic [31:0] iArg;
   logic        oReady;
   logic        oCmd;
   logic        oCmdEn;
   logic        oDone;

   int n_checks;
   int n_errors;
   int n_unstable;
   int n_done_seen;
   int en_cycles;

   sd_cmd_serializer #(.NCC_BITS(NCC)) dut (
      .Clk        (Clk),
      .nResetSync (nResetSync),
      .iStrobe    (iStrobe),
      .iValid     (iValid),
      .iIndex     (iIndex),
      .iArg       (iArg),
      .oReady     (oReady),
      .oCmd       (oCmd),
      .oCmdEn     (oCmdEn),
      .oDone      (oDone)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Count Clk cycles during which the line was driven.
   always @(posedge Clk) begin
      if (oCmdEn === 1'b1) en_cycles <= en_cycles + 1;
   end

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      int          sp;
      logic [47:0] exp;
   } vec_t;

   vec_t vt[5];

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [47:0] ref_token(input logic [5:0] idx,
                                             input logic [31:0] arg);
      logic [39:0] content;
      logic [6:0]  crc;
      logic        fb;
      content = {2'b01, idx, arg};
      crc = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb  = content[i] ^ crc[6];
         crc = {crc[5:0], 1'b0};
         if (fb) crc = crc ^ 7'h09;
      end
      return {content, crc, 1'b1};
   endfunction

   // One bit period of sp Clk (sp=0 picks 1..7); samples the bit before the strobe.
   task automatic do_strobe(input int sp, output logic b, output logic en);
      int   n;
      logic b0;
      n  = (sp == 0) ? int'($urandom_range(1, 7)) : sp;
      b0 = oCmd;
      if (oDone !== 1'b0) n_done_seen++;
      for (int i = 0; i < n - 1; i++) begin
         iStrobe = 1'b0;
         @(negedge Clk);
         if (oCmd !== b0) n_unstable++;
         if (oDone !== 1'b0) n_done_seen++;
      end
      b  = oCmd;
      en = oCmdEn;
      if (b !== b0) n_unstable++;
      iStrobe = 1'b1;
      @(negedge Clk);
      iStrobe = 1'b0;
   endtask

   task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input logic coinc);
      int t;
      t = 0;
      while (oReady !== 1'b1 && t < 200) begin
         @(negedge Clk);
         t++;
      end
      check("ready_wait", (t < 200), 1);
      iValid  = 1'b1;
      iIndex  = idx;
      iArg    = arg;
      iStrobe = coinc;
      @(negedge Clk);
      iValid  = 1'b0;
      iStrobe = 1'b0;
      check("accept_en", oCmdEn, 1);
      check("accept_start", oCmd, 0);
      check("accept_busy", oReady, 0);
   endtask

   task automatic capture(input int sp, output logic [47:0] tok,
                          output int ecyc);
      logic b;
      logic en;
      int   e0;
      int   en_low;
      int   gap_en;
      n_unstable  = 0;
      n_done_seen = 0;
      en_low      = 0;
      gap_en      = 0;
      e0          = en_cycles;
      for (int k = 0; k < 48; k++) begin
         do_strobe(sp, b, en);
         tok[47-k] = b;
         if (en !== 1'b1) en_low++;
      end
      check("done_pulse", oDone, 1);
      check("end_release", oCmdEn, 0);
      check("end_line_high", oCmd, 1);
      ecyc = en_cycles - e0;
      iStrobe = 1'b0;
      @(negedge Clk);
      check("done_clear", oDone, 0);
      for (int g = 0; g < NCC; g++) begin
         check("gap_busy", oReady, 0);
         do_strobe(sp, b, en);
         if (en !== 1'b0) gap_en++;
      end
      check("ready_back", oReady, 1);
      check("en_steady", en_low, 0);
      check("gap_released", gap_en, 0);
      check("bit_stable", n_unstable, 0);
      check("no_stray_done", n_done_seen, 0);
   endtask

   initial begin
      logic [47:0] tok;
      int          ec;
      logic        b;
      logic        en;
      logic [5:0]  ridx;
      logic [31:0] rarg;

      n_checks   = 0;
      n_errors   = 0;
      en_cycles  = 0;
      nResetSync = 1'b0;
      iStrobe    = 1'b0;
      iValid     = 1'b0;
      iIndex     = '0;
      iArg       = '0;

      vt[0] = '{6'd0,  32'h0000_0000, 4, 48'h40_0000_0000_95};
      vt[1] = '{6'd8,  32'h0000_01AA, 1, 48'h48_0000_01AA_87};
      vt[2] = '{6'd17, 32'h0000_0000, 2, 48'h51_0000_0000_55};
      vt[3] = '{6'd55, 32'h0000_0000, 3, 48'h77_0000_0000_65};
      vt[4] = '{6'd41, 32'h4000_0000, 5, 48'h69_4000_0000_77};

      repeat (3) @(negedge Clk);
      check("rst_ready", oReady, 1);
      check("rst_cmd", oCmd, 1);
      check("rst_en", oCmdEn, 0);
      check("rst_done", oDone, 0);
      nResetSync = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < 5; i++) begin
         start_cmd(vt[i].idx, vt[i].arg, 1'b0);
         capture(vt[i].sp, tok, ec);
         check($sformatf("token_cmd%0d", vt[i].idx), tok, vt[i].exp);
         check($sformatf("en_cycles_cmd%0d", vt[i].idx), ec, 48 * vt[i].sp);
      end

      // Strobe coincident with accept must not advance the start bit.
      start_cmd(6'd0, 32'h0, 1'b1);
      capture(3, tok, ec);
      check("coinc_token", tok, 48'h40_0000_0000_95);
      check("coinc_en_cycles", ec, 48 * 3);

      // iValid held with a new index while busy: only taken after the gap.
      start_cmd(6'd17, 32'h0, 1'b0);
      iValid = 1'b1;
      iIndex = 6'd55;
      iArg   = 32'h0;
      capture(2, tok, ec);
      check("hold_first_token", tok, 48'h51_0000_0000_55);
      @(negedge Clk);
      iValid = 1'b0;
      check("hold_second_accept", oCmdEn, 1);
      check("hold_second_start", oCmd, 0);
      capture(2, tok, ec);
      check("hold_second_token", tok, 48'h77_0000_0000_65);

      // Reset at content bit 20 aborts the command.
      start_cmd(6'd17, 32'hDEAD_BEEF, 1'b0);
      for (int k = 0; k < 20; k++) do_strobe(1, b, en);
      nResetSync = 1'b0;
      @(negedge Clk);
      check("abort_en", oCmdEn, 0);
      check("abort_cmd", oCmd, 1);
      check("abort_ready", oReady, 1);
      check("abort_done", oDone, 0);
      nResetSync = 1'b1;
      n_done_seen = 0;
      for (int k = 0; k < 5; k++) begin
         iStrobe = 1'b1;
         @(negedge Clk);
         if (oDone !== 1'b0 || oCmdEn !== 1'b0) n_done_seen++;
      end
      iStrobe = 1'b0;
      check("abort_quiet", n_done_seen, 0);
      start_cmd(6'd0, 32'h0, 1'b0);
      capture(3, tok, ec);
      check("post_abort_token", tok, 48'h40_0000_0000_95);

      // Random commands with random strobe spacing per bit.
      for (int r = 0; r < 200; r++) begin
         ridx = 6'($urandom_range(0, 63));
         rarg = $urandom;
         start_cmd(ridx, rarg, 1'($urandom_range(0, 1)));
         capture(0, tok, ec);
         check($sformatf("rand_token_%0d", r), tok, ref_token(ridx, rarg));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
